// File: rtl/cp0_exc_ctrl.sv
// Exception entry/return controller: turns decoder flags into CP0 command strobes and PC redirects,
// and keeps STATUS, nesting depth and fault state in step with CP0.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter int          MAX_DEPTH  = 6,
    parameter int          CNT_W      = 16
) (
    input  logic              cp0_clk,
    input  logic              cp0_rst,
    input  logic              is_syscall,
    input  logic              is_break,
    input  logic              is_teq,
    input  logic              teq_equal,
    input  logic              is_eret,
    input  logic              is_mtc0,
    input  logic              is_mfc0,
    input  logic [4:0]        cp0_addr,
    input  logic [31:0]       gpr_data,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       epc_in,
    output logic              cp0_ena,
    output logic              mfc0_o,
    output logic              mtc0_o,
    output logic              eret_o,
    output logic [4:0]        cause,
    output logic [31:0]       exc_pc,
    output logic              pc_redirect,
    output logic [31:0]       pc_target,
    output logic [2:0]        depth,
    output logic              fault,
    output logic              eret_err,
    output logic [CNT_W-1:0]  exc_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NESTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [2:0] MAX_D      = 3'(MAX_DEPTH);
    localparam logic [4:0] STATUS_REG = 5'd12;

    state_t             state_reg;
    logic [31:0]        status_sh_reg;
    logic [2:0]         depth_reg;
    logic               fault_reg;
    logic               eret_err_reg;
    logic [CNT_W-1:0]   exc_count_reg;

    logic               exc_req;
    logic               kind_en;
    logic [4:0]         kind_code;
    logic               mtc0_act;
    logic               take;
    logic               eret_act;
    logic               eret_bad;
    logic               mfc0_act;

    // Highest-priority exception kind and its enable from the STATUS shadow
    always_comb begin
        kind_code = 5'd0;
        kind_en   = 1'b0;
        if (is_syscall) begin
            kind_code = 5'd8;
            kind_en   = status_sh_reg[0] & status_sh_reg[1];
        end else if (is_break) begin
            kind_code = 5'd9;
            kind_en   = status_sh_reg[0] & status_sh_reg[2];
        end else if (is_teq && teq_equal) begin
            kind_code = 5'd13;
            kind_en   = status_sh_reg[0] & status_sh_reg[3];
        end
    end

    // Reset gates the strobes so a redirect drops the instant cp0_rst rises
    assign mtc0_act = ~cp0_rst & is_mtc0;
    assign exc_req  = ~cp0_rst & ~is_mtc0 & (is_syscall | is_break | (is_teq & teq_equal));
    assign take     = exc_req & kind_en & (state_reg != ST_FAULT) & (depth_reg < MAX_D);
    assign eret_act = ~cp0_rst & ~is_mtc0 & ~take & is_eret & (depth_reg != 3'd0);
    assign eret_bad = ~cp0_rst & ~is_mtc0 & ~take & is_eret & (depth_reg == 3'd0);
    assign mfc0_act = ~cp0_rst & ~is_mtc0 & ~take & ~is_eret & is_mfc0;

    assign cp0_ena     = mtc0_act | take | eret_act | mfc0_act;
    assign mtc0_o      = mtc0_act;
    assign eret_o      = eret_act;
    assign mfc0_o      = mfc0_act;
    assign cause       = take ? kind_code : 5'd0;
    assign exc_pc      = take ? pc_in : 32'd0;
    assign pc_redirect = take | eret_act;
    assign pc_target   = take ? EXC_VECTOR : (eret_act ? epc_in : 32'd0);

    assign depth     = depth_reg;
    assign fault     = fault_reg;
    assign eret_err  = eret_err_reg;
    assign exc_count = exc_count_reg;

    // State moves on the falling edge so it lands together with CP0's own update
    always_ff @(negedge cp0_clk or posedge cp0_rst) begin
        if (cp0_rst) begin
            state_reg     <= ST_IDLE;
            status_sh_reg <= 32'd0;
            depth_reg     <= 3'd0;
            fault_reg     <= 1'b0;
            eret_err_reg  <= 1'b0;
            exc_count_reg <= '0;
        end else begin
            if (take) begin
                status_sh_reg <= status_sh_reg << 5;
                depth_reg     <= depth_reg + 3'd1;
                state_reg     <= ST_NESTED;
                if (exc_count_reg != '1) begin
                    exc_count_reg <= exc_count_reg + 1'b1;
                end
            end else if (eret_act) begin
                status_sh_reg <= status_sh_reg >> 5;
                depth_reg     <= depth_reg - 3'd1;
                if (state_reg == ST_NESTED && depth_reg == 3'd1) begin
                    state_reg <= ST_IDLE;
                end
            end else if (mtc0_act && cp0_addr == STATUS_REG) begin
                status_sh_reg <= gpr_data;
            end

            if (exc_req && depth_reg == MAX_D) begin
                state_reg <= ST_FAULT;
                fault_reg <= 1'b1;
            end

            if (eret_bad) begin
                eret_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: hand-computed strobes, redirects and state after each step.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_syscall = 0, is_break = 0, is_teq = 0, teq_equal = 0;
    logic        is_eret = 0, is_mtc0 = 0, is_mfc0 = 0;
    logic [4:0]  cp0_addr = 0;
    logic [31:0] gpr_data = 0, pc_in = 0, epc_in = 0;
    logic        cp0_ena, mfc0_o, mtc0_o, eret_o, pc_redirect, fault, eret_err;
    logic [4:0]  cause;
    logic [31:0] exc_pc, pc_target;
    logic [2:0]  depth;
    logic [15:0] exc_count;

    int total = 0;
    int bad   = 0;

    cp0_exc_ctrl dut (
        .cp0_clk(clk), .cp0_rst(rst),
        .is_syscall(is_syscall), .is_break(is_break), .is_teq(is_teq), .teq_equal(teq_equal),
        .is_eret(is_eret), .is_mtc0(is_mtc0), .is_mfc0(is_mfc0),
        .cp0_addr(cp0_addr), .gpr_data(gpr_data), .pc_in(pc_in), .epc_in(epc_in),
        .cp0_ena(cp0_ena), .mfc0_o(mfc0_o), .mtc0_o(mtc0_o), .eret_o(eret_o),
        .cause(cause), .exc_pc(exc_pc), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .depth(depth), .fault(fault), .eret_err(eret_err), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_in();
        is_syscall = 0; is_break = 0; is_teq = 0; teq_equal = 0;
        is_eret = 0; is_mtc0 = 0; is_mfc0 = 0;
        cp0_addr = 0; gpr_data = 0; pc_in = 0; epc_in = 0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled before the falling edge
    task automatic start_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic end_cyc();
        @(negedge clk);
        #1;
        clear_in();
    endtask

    task automatic wr_status(input logic [31:0] val);
        start_cyc();
        is_mtc0 = 1; cp0_addr = 5'd12; gpr_data = val;
        #1;
        chk("mtc0_strobe", {30'd0, cp0_ena, mtc0_o}, 32'h3);
        end_cyc();
        chk("status_after_mtc0", dut.status_sh_reg, val);
    endtask

    initial begin
        #3;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_flags", {30'd0, fault, eret_err}, 32'd0);
        chk("rst_count", 32'(exc_count), 32'd0);
        chk("rst_ena", 32'(cp0_ena), 32'd0);
        #4 rst = 1'b0;

        // Test 1: enable all kinds, SYSCALL
        wr_status(32'h0000_000F);
        start_cyc();
        is_syscall = 1; pc_in = 32'h0040_0100;
        #1;
        chk("t1_cause", 32'(cause), 32'd8);
        chk("t1_exc_pc", exc_pc, 32'h0040_0100);
        chk("t1_target", pc_target, 32'h0040_0004);
        chk("t1_redir_ena", {30'd0, pc_redirect, cp0_ena}, 32'h3);
        end_cyc();
        chk("t1_depth", 32'(depth), 32'd1);
        chk("t1_status", dut.status_sh_reg, 32'h0000_01E0);
        chk("t1_count", 32'(exc_count), 32'd1);

        // Test 2: ERET back to level 0
        start_cyc();
        is_eret = 1; epc_in = 32'h0040_0100;
        #1;
        chk("t2_eret_o", 32'(eret_o), 32'd1);
        chk("t2_target", pc_target, 32'h0040_0100);
        chk("t2_redir", 32'(pc_redirect), 32'd1);
        chk("t2_cause", 32'(cause), 32'd0);
        end_cyc();
        chk("t2_depth", 32'(depth), 32'd0);
        chk("t2_status", dut.status_sh_reg, 32'h0000_000F);
        chk("t2_state", 32'(dut.state_reg), 32'd0);

        // MFC0: strobe only, no state change
        start_cyc();
        is_mfc0 = 1; cp0_addr = 5'd12;
        #1;
        chk("mfc0_strobe", {29'd0, cp0_ena, mfc0_o, mtc0_o}, 32'h6);
        end_cyc();
        chk("mfc0_status", dut.status_sh_reg, 32'h0000_000F);

        // Test 3: TEQ without and with trap condition
        start_cyc();
        is_teq = 1; teq_equal = 0; pc_in = 32'h0040_0200;
        #1;
        chk("t3_noeq_ena_redir", {30'd0, cp0_ena, pc_redirect}, 32'd0);
        end_cyc();
        chk("t3_noeq_count", 32'(exc_count), 32'd1);
        start_cyc();
        is_teq = 1; teq_equal = 1; pc_in = 32'h0040_0204;
        #1;
        chk("t3_cause", 32'(cause), 32'd13);
        chk("t3_exc_pc", exc_pc, 32'h0040_0204);
        end_cyc();
        chk("t3_count", 32'(exc_count), 32'd2);
        start_cyc();
        is_eret = 1; epc_in = 32'h0040_0204;
        end_cyc();
        chk("t3_depth_back", 32'(depth), 32'd0);

        // Test 4: disabled BREAK, then ERET at depth 0
        wr_status(32'h0000_0000);
        start_cyc();
        is_break = 1; pc_in = 32'h0040_0300;
        #1;
        chk("t4_brk_ena_redir", {30'd0, cp0_ena, pc_redirect}, 32'd0);
        chk("t4_brk_cause", 32'(cause), 32'd0);
        end_cyc();
        chk("t4_count", 32'(exc_count), 32'd2);
        start_cyc();
        is_eret = 1; epc_in = 32'h0040_0300;
        #1;
        chk("t4_eret0_strobes", {29'd0, cp0_ena, eret_o, pc_redirect}, 32'd0);
        end_cyc();
        chk("t4_eret_err", 32'(eret_err), 32'd1);

        // Test 5: nest to MAX_DEPTH, then overflow
        for (int i = 0; i < 6; i++) begin
            wr_status(32'h0000_000F);
            start_cyc();
            is_syscall = 1; pc_in = 32'h0040_1000 + 32'(i * 4);
            #1;
            chk("t5_nest_redir", 32'(pc_redirect), 32'd1);
            end_cyc();
            chk("t5_nest_depth", 32'(depth), 32'(i + 1));
        end
        chk("t5_count6", 32'(exc_count), 32'd8);
        wr_status(32'h0000_000F);
        start_cyc();
        is_syscall = 1; pc_in = 32'h0040_2000;
        #1;
        chk("t5_over_ena_redir", {30'd0, cp0_ena, pc_redirect}, 32'd0);
        end_cyc();
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_over_depth", 32'(depth), 32'd6);
        chk("t5_state", 32'(dut.state_reg), 32'd2);
        chk("t5_over_count", 32'(exc_count), 32'd8);
        start_cyc();
        is_eret = 1; epc_in = 32'h0000_1234;
        #1;
        chk("t5_fault_eret_target", pc_target, 32'h0000_1234);
        end_cyc();
        chk("t5_fault_eret_depth", 32'(depth), 32'd5);
        wr_status(32'h0000_000F);
        start_cyc();
        is_syscall = 1; pc_in = 32'h0040_3000;
        #1;
        chk("t5_fault_ignore", 32'(pc_redirect), 32'd0);
        end_cyc();
        chk("t5_fault_ignore_depth", 32'(depth), 32'd5);
        for (int i = 0; i < 2; i++) begin
            start_cyc();
            is_eret = 1; epc_in = 32'h0000_2000;
            end_cyc();
        end
        chk("t5_depth3", 32'(depth), 32'd3);

        // Test 6: asynchronous reset mid-cycle while an ERET is redirecting
        start_cyc();
        is_eret = 1; epc_in = 32'h0000_3000;
        #1;
        chk("t6_pre_redir", 32'(pc_redirect), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_depth", 32'(depth), 32'd0);
        chk("t6_flags", {30'd0, fault, eret_err}, 32'd0);
        chk("t6_outs", {28'd0, cp0_ena, eret_o, pc_redirect, mtc0_o}, 32'd0);
        chk("t6_target", pc_target, 32'd0);
        chk("t6_count", 32'(exc_count), 32'd0);
        chk("t6_status", dut.status_sh_reg, 32'd0);
        end_cyc();
        #2 rst = 1'b0;

        // After reset the fault is gone and exceptions are taken again
        wr_status(32'h0000_000F);
        start_cyc();
        is_break = 1; pc_in = 32'h0040_4000;
        #1;
        chk("post_cause", 32'(cause), 32'd9);
        end_cyc();
        chk("post_depth", 32'(depth), 32'd1);
        chk("post_count", 32'(exc_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
